// File: rtl/lane_bank_sweeper.sv
// Round-robin sequencer sharing a lane-enable vector between two banks:
// the winner's lanes turn on one per cycle, stay fully on for a hold count, then release together.
module lane_bank_sweeper #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SPLIT  = 10,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [HOLD_W-1:0] hold_a,
  input  logic [HOLD_W-1:0] hold_b,
  output logic [1:0]        grant,
  output logic [WIDTH-1:0]  o,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_A = IDX_W'(SPLIT - 1);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(WIDTH - SPLIT - 1);
  localparam logic [IDX_W-1:0] BASE_B = IDX_W'(SPLIT);

  typedef enum logic [1:0] {IDLE, SWEEP, HOLD, RELEASE} state_t;

  state_t             state, state_n;
  logic [1:0]         grant_n;
  logic [WIDTH-1:0]   o_n;
  logic               busy_n, done_n;
  logic               ptr, ptr_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [HOLD_W-1:0]  hcnt, hcnt_n;
  logic               win_b;
  logic [IDX_W-1:0]   lane;
  logic [IDX_W-1:0]   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 2'b00;
      o     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ptr   <= 1'b0;
      idx   <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      o     <= o_n;
      busy  <= busy_n;
      done  <= done_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      hcnt  <= hcnt_n;
    end
  end

  // Next-state and registered-output logic; the full bank always gets one
  // HOLD pass so that H=0 still shows it for exactly one cycle.
  always_comb begin
    state_n = state;
    grant_n = grant;
    o_n     = o;
    done_n  = 1'b0;
    ptr_n   = ptr;
    idx_n   = idx;
    hcnt_n  = hcnt;
    win_b   = (req == 2'b10) || ((req == 2'b11) && ptr);
    lane    = (grant[1] ? BASE_B : IDX_W'(0)) + idx;
    last    = grant[1] ? LAST_B : LAST_A;

    case (state)
      IDLE: begin
        o_n = '0;
        if (req != 2'b00) begin
          grant_n = win_b ? 2'b10 : 2'b01;
          hcnt_n  = win_b ? hold_b : hold_a;
          idx_n   = '0;
          ptr_n   = ~win_b;
          state_n = SWEEP;
        end
      end
      SWEEP: begin
        o_n   = o | (WIDTH'(1) << lane);
        idx_n = idx + IDX_W'(1);
        if (idx == last) state_n = HOLD;
      end
      HOLD: begin
        if (hcnt == '0) begin
          o_n     = '0;
          grant_n = 2'b00;
          done_n  = 1'b1;
          state_n = RELEASE;
        end else begin
          hcnt_n = hcnt - HOLD_W'(1);
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_lane_bank_sweeper.sv
// Directed, table-driven bench for lane_bank_sweeper with a few hand-written multi-cycle sequences.
module tb_lane_bank_sweeper;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  hold_a, hold_b;
  logic [1:0]  grant;
  logic [15:0] o;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;

  lane_bank_sweeper #(.WIDTH(16), .SPLIT(10), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hold_a(hold_a), .hold_b(hold_b),
    .grant(grant), .o(o), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  ha;
    logic [3:0]  hb;
    logic [1:0]  g;
    logic [15:0] o;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [3:0] ha, input logic [3:0] hb,
                      input logic [1:0] g, input logic [15:0] ov, input logic b, input logic d);
    vec_t v;
    v.req = r; v.ha = ha; v.hb = hb; v.g = g; v.o = ov; v.busy = b; v.done = d;
    tbl.push_back(v);
  endtask

  // Bank A transaction: hold h0 at grant, hold_a changed to hl afterwards, req[0] dropped from edge drop_k.
  task automatic add_a(input int h0, input int hl, input int drop_k);
    push(2'b01, 4'(h0), 4'd0, 2'b01, 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++)
      push((k >= drop_k) ? 2'b00 : 2'b01, 4'(hl), 4'd0, 2'b01, 16'((32'd1 << k) - 1), 1'b1, 1'b0);
    for (int j = 1; j <= h0; j++)
      push(2'b00, 4'(hl), 4'd0, 2'b01, 16'h03FF, 1'b1, 1'b0);
    push(2'b00, 4'(hl), 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1);
    push(2'b00, 4'(hl), 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0);
  endtask

  // Bank B transaction with hold h; hold_a held at 9 to show it is not the one sampled.
  task automatic add_b(input int h);
    push(2'b10, 4'd9, 4'(h), 2'b10, 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++)
      push(2'b10, 4'd9, 4'd0, 2'b10, 16'(((32'd1 << k) - 1) << 10), 1'b1, 1'b0);
    for (int j = 1; j <= h; j++)
      push(2'b00, 4'd9, 4'd0, 2'b10, 16'hFC00, 1'b1, 1'b0);
    push(2'b00, 4'd9, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1);
    push(2'b00, 4'd9, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] seq [3];
    logic [1:0] pg;
    int         ng;

    add_a(2, 2, 11);
    add_b(0);
    add_a(1, 1, 3);
    add_a(2, 7, 3);
    add_b(2);

    rst_n = 1'b0; req = 2'b00; hold_a = 4'd0; hold_b = 4'd0;
    #7;
    chk("reset.o", 32'(o), 32'h0);
    chk("reset.grant", 32'(grant), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      req = tbl[i].req; hold_a = tbl[i].ha; hold_b = tbl[i].hb;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d.o", i), 32'(o), 32'(tbl[i].o));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(tbl[i].done));
    end

    // Both banks requesting continuously from reset: expect A, B, A.
    hold_a = 4'd0; hold_b = 4'd1;
    do_reset();
    req = 2'b11;
    seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b00;
    pg = 2'b00; ng = 0;
    for (int cyc = 0; cyc < 120 && ng < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (grant != 2'b00 && pg == 2'b00) begin
        seq[ng] = grant;
        ng++;
      end
      pg = grant;
      chk("both.no_overlap", 32'((o[9:0] != 10'd0) && (o[15:10] != 6'd0)), 32'h0);
      if (grant == 2'b01) chk("both.a_only", 32'(o[15:10]), 32'h0);
      if (grant == 2'b10) chk("both.b_only", 32'(o[9:0]), 32'h0);
    end
    chk("both.grant0", 32'(seq[0]), 32'h1);
    chk("both.grant1", 32'(seq[1]), 32'h2);
    chk("both.grant2", 32'(seq[2]), 32'h1);

    // Third grant went to A, so ptr now prefers B; sweep to 0x001F then reset asynchronously.
    req = 2'b00;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("midrst.pre_o", 32'(o), 32'h001F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.o", 32'(o), 32'h0);
    chk("midrst.grant", 32'(grant), 32'h0);
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 2'b11;
    @(posedge clk);
    #1;
    chk("midrst.ptr_grant", 32'(grant), 32'h1);
    chk("midrst.ptr_busy", 32'(busy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
